dac_sample_scheduler: RTL and testbench

// - Paces audio samples into the sigma-delta DAC core at an exact average SAMPLE_HZ, derived from sysclk.
// - Accepts samples from an upstream source (ROM player / UART loader) over a valid/ready handshake.
// - Buffers them in a small FIFO and presents one sample per sample tick on the DAC's parallel input.
// - Handles start-up priming, underrun, mute and stop, so the DAC never sees an undefined or stale word.

---
 rtl/dac_sample_scheduler.sv | 131 +++++++++++++
 tb/tb_dac_sample_scheduler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_scheduler.sv
// dac_sample_scheduler: paces buffered upstream samples into a DAC at an exact average SAMPLE_HZ.
// Ports: sysclk_i/rst_n_i clock and async active-low reset; enable_i run/stop; mute_i force midscale;
//   s_data_i/s_valid_i/s_ready_o upstream handshake; dac_sample_o/dac_strobe_o DAC word and update pulse;
//   underrun_o empty-tick pulse; fifo_level_o occupancy; playing_o FSM in PLAY.
// Option UNDERRUN_COUNT_EN adds underrun_cnt_o, a saturating 16-bit underrun counter.
module dac_sample_scheduler #(
  parameter int CLK_HZ     = 60_000_000,
  parameter int SAMPLE_HZ  = 44_100,
  parameter int BITLEN     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int ACC_W      = 32
) (
  input  logic                          sysclk_i,
  input  logic                          rst_n_i,
  input  logic                          enable_i,
  input  logic                          mute_i,
  input  logic [BITLEN-1:0]             s_data_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  output logic [BITLEN-1:0]             dac_sample_o,
  output logic                          dac_strobe_o,
  output logic                          underrun_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          playing_o
`ifdef UNDERRUN_COUNT_EN
  ,
  output logic [15:0]                   underrun_cnt_o
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [BITLEN-1:0] MID = {1'b1, {(BITLEN-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_t;
  state_t state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [BITLEN-1:0] sample_q, sample_d, last_q, last_d;
  logic strobe_q, strobe_d, under_q, under_d;
  logic [BITLEN-1:0] mem_q [FIFO_DEPTH];
  logic tick, full, empty, push, pop, flush;
  // Fractional phase accumulator: wraps by CLK_HZ, giving exactly SAMPLE_HZ ticks per CLK_HZ cycles.
  assign acc_sum = acc_q + ACC_W'(SAMPLE_HZ);
  assign tick = acc_sum >= ACC_W'(CLK_HZ);
  assign full = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign empty = cnt_q == '0;
  // Ready comes from registered occupancy only, so a same-cycle pop never opens the input.
  assign s_ready_o = (state_q != IDLE) && !full;
  assign push = s_valid_i && s_ready_o;
  always_comb begin
    state_d = state_q;
    sample_d = sample_q;
    last_d = last_q;
    strobe_d = 1'b0;
    under_d = 1'b0;
    pop = 1'b0;
    flush = 1'b0;
    // Holding acc at zero in IDLE means every PRIME entry starts from a cleared phase.
    acc_d = (state_q == IDLE) ? '0 : (tick ? acc_sum - ACC_W'(CLK_HZ) : acc_sum);
    case (state_q)
      IDLE: begin
        flush = 1'b1;
        sample_d = MID;
        state_d = enable_i ? PRIME : IDLE;
      end
      PRIME: begin
        flush = !enable_i;
        state_d = !enable_i ? IDLE : (cnt_q >= (AW+1)'(FIFO_DEPTH/2)) ? PLAY : PRIME;
      end
      PLAY: begin
        if (!enable_i) begin
          state_d = IDLE;
          flush = 1'b1;
          sample_d = MID;
          strobe_d = 1'b1;
        end else if (tick) begin
          strobe_d = 1'b1;
          pop = !empty;
          under_d = empty;
          // On underrun the last popped word is repeated rather than leaving the DAC stale-undefined.
          last_d = empty ? last_q : mem_q[rd_q];
          sample_d = mute_i ? MID : last_d;
        end
      end
      default: state_d = IDLE;
    endcase
    wr_d = flush ? '0 : wr_q + AW'(push);
    rd_d = flush ? '0 : rd_q + AW'(pop);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      acc_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      sample_q <= MID;
      last_q <= MID;
      strobe_q <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      sample_q <= sample_d;
      last_q <= last_d;
      strobe_q <= strobe_d;
      under_q <= under_d;
    end
  end
  // Storage needs no reset: occupancy and pointers alone define which entries are live.
  always_ff @(posedge sysclk_i) begin
    if (push) mem_q[wr_q] <= s_data_i;
  end
  assign dac_sample_o = sample_q;
  assign dac_strobe_o = strobe_q;
  assign underrun_o = under_q;
  assign fifo_level_o = cnt_q;
  assign playing_o = state_q == PLAY;
`ifdef UNDERRUN_COUNT_EN
  logic [15:0] ucnt_q, ucnt_d;
  assign ucnt_d = (state_q == IDLE && enable_i) ? '0 : (under_d && ucnt_q != 16'hFFFF) ? ucnt_q + 16'd1 : ucnt_q;
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) ucnt_q <= '0;
    else ucnt_q <= ucnt_d;
  end
  assign underrun_cnt_o = ucnt_q;
`endif
endmodule

// File: tb/tb_dac_sample_scheduler.sv
// tb_dac_sample_scheduler: randomized and directed checks of dac_sample_scheduler against a queue-based reference model.
module tb_dac_sample_scheduler;
  localparam int CLK_HZ = 1000;
  localparam int SR = 300;
  localparam int D = 8;
  localparam logic [15:0] MID = 16'h8000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic mute = 1'b0;
  logic s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic s_ready, dac_strobe, underrun, playing;
  logic [15:0] dac_sample;
  logic [3:0] fifo_level;
`ifdef UNDERRUN_COUNT_EN
  logic [15:0] underrun_cnt;
`endif
  int vectors = 0;
  int miscompares = 0;
  int m_st, m_c, m_ucnt, cyc;
  logic [15:0] q[$];
  logic [15:0] m_last, m_sample;
  logic m_strobe, m_under, m_push;

  dac_sample_scheduler #(.CLK_HZ(CLK_HZ), .SAMPLE_HZ(SR), .BITLEN(16), .FIFO_DEPTH(D), .ACC_W(32)) dut (
    .sysclk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .mute_i(mute),
    .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .dac_sample_o(dac_sample), .dac_strobe_o(dac_strobe), .underrun_o(underrun),
    .fifo_level_o(fifo_level), .playing_o(playing)
`ifdef UNDERRUN_COUNT_EN
    , .underrun_cnt_o(underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_c = 0; m_ucnt = 0; q.delete();
    m_last = MID; m_sample = MID; m_strobe = 0; m_under = 0; m_push = 0;
  endtask

  // Reference: tick k occurs where floor(n*SR/CLK) steps, n counted from the cycle PRIME is entered.
  task automatic model_edge();
    int nst;
    bit tick;
    m_push = s_valid && m_st != 0 && q.size() < D;
    tick = m_st != 0 && ((m_c + 1) * SR / CLK_HZ != m_c * SR / CLK_HZ);
    m_strobe = 0; m_under = 0; nst = m_st;
    if (m_st == 0) begin
      q.delete(); m_sample = MID;
      if (enable) begin nst = 1; m_ucnt = 0; end
    end else if (!enable) begin
      q.delete(); nst = 0;
      if (m_st == 2) begin m_sample = MID; m_strobe = 1; end
    end else begin
      if (m_st == 1 && q.size() >= D / 2) nst = 2;
      if (m_st == 2 && tick) begin
        m_strobe = 1;
        if (q.size() > 0) m_last = q.pop_front();
        else begin m_under = 1; if (m_ucnt < 65535) m_ucnt++; end
        m_sample = mute ? MID : m_last;
      end
      if (m_push) q.push_back(s_data);
    end
    m_c = (m_st == 0) ? 0 : (m_c + 1) % CLK_HZ;
    m_st = nst;
  endtask

  task automatic check_all();
    chk("sample", 32'(dac_sample), 32'(m_sample));
    chk("strobe", 32'(dac_strobe), 32'(m_strobe));
    chk("underrun", 32'(underrun), 32'(m_under));
    chk("level", 32'(fifo_level), 32'(q.size()));
    chk("playing", 32'(playing), 32'(m_st == 2));
    chk("ready", 32'(s_ready), 32'(m_st != 0 && q.size() < D));
`ifdef UNDERRUN_COUNT_EN
    chk("ucnt", 32'(underrun_cnt), 32'(m_ucnt));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    cyc++;
  endtask

  initial begin
    int strobes, last, idx, k, pre;
    bit seen;
    logic [15:0] got[$];
    logic [15:0] w[4];
    cyc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_sample", 32'(dac_sample), 32'h8000);
    chk("rst_ready", 32'(s_ready), 0);
    rst_n = 1'b1;

    enable = 1; s_valid = 1; s_data = 16'($urandom);
    for (int i = 0; i < 50 && !playing; i++) begin s_data = 16'($urandom); step(); end
    chk("prime_to_play", 32'(playing), 1);
    strobes = 0; last = -1;
    repeat (1000) begin
      s_data = 16'($urandom);
      step();
      if (dac_strobe) begin
        if (last >= 0) chk("interval", 32'((cyc - last) inside {3, 4}), 1);
        last = cyc; strobes++;
      end
    end
    chk("rate", 32'(strobes), 300);

    enable = 0; s_valid = 0;
    step();
    chk("stop_sample", 32'(dac_sample), 32'h8000);
    chk("stop_strobe", 32'(dac_strobe), 1);
    chk("stop_level", 32'(fifo_level), 0);
    chk("stop_playing", 32'(playing), 0);
    step();

    enable = 1; idx = 1; s_data = 16'(idx); s_valid = 1;
    for (int i = 0; i < 400 && got.size() < 16; i++) begin
      step();
      if (dac_strobe && playing && !underrun) got.push_back(dac_sample);
      if (m_push) idx++;
      s_data = 16'(idx);
      s_valid = idx <= 16 && $urandom_range(0, 3) != 0;
    end
    chk("order_count", 32'(got.size()), 16);
    for (int i = 0; i < got.size(); i++) chk("order", 32'(got[i]), 32'(i + 1));

    enable = 0; s_valid = 0;
    step(); step();
    foreach (w[i]) w[i] = 16'($urandom);
    got.delete();
    enable = 1; k = 0; s_valid = 1; s_data = w[0];
    for (int i = 0; i < 40 && k < 4; i++) begin
      step();
      if (m_push) k++;
      if (k < 4) s_data = w[k]; else s_valid = 0;
    end
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      if (dac_strobe && !underrun) got.push_back(dac_sample);
      if (underrun) begin seen = 1; chk("under_sample", 32'(dac_sample), 32'(w[3])); end
    end
    chk("under_seen", 32'(seen), 1);
    chk("under_words", 32'(got.size()), 4);
    for (int i = 0; i < got.size() && i < 4; i++) chk("under_order", 32'(got[i]), 32'(w[i]));
`ifdef UNDERRUN_COUNT_EN
    chk("under_cnt", 32'(underrun_cnt), 1);
`endif

    s_valid = 1; s_data = 16'h1234;
    for (int i = 0; i < 40 && q.size() < 3; i++) step();
    s_valid = 0; mute = 1; pre = q.size(); seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (dac_strobe) begin
        seen = 1;
        chk("mute_sample", 32'(dac_sample), 32'h8000);
        chk("mute_level", 32'(fifo_level), 32'(pre - 1));
      end
    end
    chk("mute_seen", 32'(seen), 1);

    mute = 0;
    for (int i = 0; i < 3000; i++) begin
      s_valid = $urandom_range(0, 99) < 35;
      s_data = 16'($urandom);
      if ($urandom_range(0, 19) == 0) mute = ~mute;
      enable = enable ? ($urandom_range(0, 299) != 0) : ($urandom_range(0, 9) == 0);
      if (i == 1500) begin
        rst_n = 0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
